// File: rtl/operand_loader.sv
// Serial byte loader assembling A(16)/B(16)/C(8) frames; define OPERAND_LOADER_CHECKSUM_EN for a trailing XOR byte.
// Latency: en strobes the cycle after the edge accepting the final byte; one frame per (frame bytes + 1) cycles.
// Backpressure: din_ready drops only for the single ISSUE cycle; stalled partial frames are dropped after TIMEOUT_CYCLES.
module operand_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic [7:0]  c,
    output logic        en,
    output logic        busy,
    output logic        frame_err
);

`ifdef OPERAND_LOADER_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES = 6;
`else
    localparam int unsigned FRAME_BYTES = 5;
`endif

    localparam logic [2:0]  LAST_IDX = 3'(FRAME_BYTES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        LOAD,
        ISSUE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  idx;
    logic [2:0]  idx_nx;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;
    logic        frame_err_nx;

    logic [15:0] sh_a;
    logic [15:0] sh_b;
`ifdef OPERAND_LOADER_CHECKSUM_EN
    logic [7:0]  sh_c;
`endif

    logic        accept;
    logic        last_byte;
    logic        frame_ok;
    logic        commit;

    assign din_ready = (state == LOAD);
    assign en        = (state == ISSUE);
    assign busy      = (idx != 3'd0) || (state == ISSUE);

    assign accept    = din_ready && din_valid;
    assign last_byte = accept && (idx == LAST_IDX);

`ifdef OPERAND_LOADER_CHECKSUM_EN
    // Final byte must equal the XOR of the five payload bytes already in the shadows.
    assign frame_ok = (din == (sh_a[15:8] ^ sh_a[7:0] ^ sh_b[15:8] ^ sh_b[7:0] ^ sh_c));
`else
    assign frame_ok = 1'b1;
`endif

    assign commit = last_byte && frame_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= 3'd0;
            cnt       <= 16'd0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            cnt       <= cnt_nx;
            frame_err <= frame_err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        cnt_nx       = cnt;
        frame_err_nx = 1'b0;
        case (state)
            LOAD: begin
                if (accept) begin
                    // An accepted byte always clears the idle counter, even on the would-be timeout edge.
                    cnt_nx = 16'd0;
                    if (last_byte) begin
                        idx_nx = 3'd0;
                        if (frame_ok) begin
                            state_nx = ISSUE;
                        end else begin
                            frame_err_nx = 1'b1;
                        end
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end else if (idx != 3'd0) begin
                    if (cnt == TO_LAST) begin
                        idx_nx       = 3'd0;
                        cnt_nx       = 16'd0;
                        frame_err_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end else begin
                    cnt_nx = 16'd0;
                end
            end
            ISSUE: begin
                state_nx = LOAD;
                idx_nx   = 3'd0;
                cnt_nx   = 16'd0;
            end
            default: begin
                state_nx = LOAD;
                idx_nx   = 3'd0;
                cnt_nx   = 16'd0;
            end
        endcase
    end

    // Shadow capture keeps the visible operands frozen while a frame trickles in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a <= 16'd0;
            sh_b <= 16'd0;
`ifdef OPERAND_LOADER_CHECKSUM_EN
            sh_c <= 8'd0;
`endif
        end else if (accept) begin
            case (idx)
                3'd0: sh_a[15:8] <= din;
                3'd1: sh_a[7:0]  <= din;
                3'd2: sh_b[15:8] <= din;
                3'd3: sh_b[7:0]  <= din;
`ifdef OPERAND_LOADER_CHECKSUM_EN
                3'd4: sh_c       <= din;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= 16'd0;
            b <= 16'd0;
            c <= 8'd0;
        end else if (commit) begin
            a <= sh_a;
            b <= sh_b;
`ifdef OPERAND_LOADER_CHECKSUM_EN
            c <= sh_c;
`else
            c <= din;
`endif
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader (TIMEOUT_CYCLES=4): scoreboard of expected frames popped on each en strobe.
module tb_operand_loader;

`ifdef OPERAND_LOADER_CHECKSUM_EN
    localparam int FB = 6;
`else
    localparam int FB = 5;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  c;
    logic        en;
    logic        busy;
    logic        frame_err;

    typedef struct packed {
        logic [15:0] ea;
        logic [15:0] eb;
        logic [7:0]  ec;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   err_seen = 0;
    int   exp_err = 0;
    int   last_en_cyc = -1;
    int   prev_en_cyc = -1;

    operand_loader #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .en        (en),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] cks(input logic [15:0] x, input logic [15:0] y, input logic [7:0] z);
        return x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0] ^ z;
    endfunction

    // Monitor: every en pops the oldest expected frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (en) begin
                prev_en_cyc = last_en_cyc;
                last_en_cyc = cyc;
                if (q.size() == 0) begin
                    chk("en_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("a", {16'd0, a}, {16'd0, e.ea});
                    chk("b", {16'd0, b}, {16'd0, e.eb});
                    chk("c", {24'd0, c}, {24'd0, e.ec});
                end
            end
            if (frame_err) err_seen++;
            chk("ready_vs_en", {31'd0, din_ready}, {31'd0, ~en});
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        din_valid = 1'b0;
        repeat (gap) step();
        din       = v;
        din_valid = 1'b1;
        for (int k = 0; k < 20 && !din_ready; k++) step();
        chk("ready_wait", {31'd0, din_ready}, 32'd1);
        step();
        din_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] fa, input logic [15:0] fb, input logic [7:0] fc,
                              input logic [7:0] ck, input int gapmax, input bit exp_en);
        logic [7:0]  bytes [6];
        logic [15:0] a0;
        a0    = a;
        bytes = '{fa[15:8], fa[7:0], fb[15:8], fb[7:0], fc, ck};
        if (exp_en) q.push_back(exp_t'{fa, fb, fc});
        for (int i = 0; i < FB; i++) begin
            send_byte(bytes[i], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
            if (i == 2) begin
                chk("a_stable_loading", {16'd0, a}, {16'd0, a0});
                chk("busy_loading", {31'd0, busy}, 32'd1);
            end
        end
        chk("en_latency", {31'd0, en}, {31'd0, exp_en});
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [7:0]  rc;

        din = 8'd0;
        din_valid = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_a", {16'd0, a}, 32'd0);
        chk("rst_b", {16'd0, b}, 32'd0);
        chk("rst_c", {24'd0, c}, 32'd0);
        chk("rst_en", {31'd0, en}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_ready", {31'd0, din_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Two back-to-back frames
        send_frame(16'h00AB, 16'h00C3, 8'h05, 8'h6D, 0, 1'b1);
        send_frame(16'h00AB, 16'h00FC, 8'h02, 8'h55, 0, 1'b1);
        step();
        chk("frame_period", last_en_cyc - prev_en_cyc, FB + 1);
        chk("no_err_clean", err_seen, 0);

        // Timeout after two bytes and four idle cycles
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        repeat (3) step();
        chk("to_not_yet", {31'd0, frame_err}, 32'd0);
        chk("to_busy_hold", {31'd0, busy}, 32'd1);
        step();
        chk("to_err_pulse", {31'd0, frame_err}, 32'd1);
        chk("to_busy_fall", {31'd0, busy}, 32'd0);
        step();
        chk("to_err_one_cycle", {31'd0, frame_err}, 32'd0);
        exp_err++;
        chk("to_err_count", err_seen, exp_err);
        chk("to_a_keep", {16'd0, a}, 32'h00AB);
        chk("to_b_keep", {16'd0, b}, 32'h00FC);
        chk("to_c_keep", {24'd0, c}, 32'h02);
        send_frame(16'h1234, 16'h5678, 8'h9A, cks(16'h1234, 16'h5678, 8'h9A), 0, 1'b1);

        // Byte arriving on the edge the counter would time out wins
        q.push_back(exp_t'{16'hDEAD, 16'hBEEF, 8'h77});
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 3);
        send_byte(8'hEF, 0);
        send_byte(8'h77, 0);
`ifdef OPERAND_LOADER_CHECKSUM_EN
        send_byte(cks(16'hDEAD, 16'hBEEF, 8'h77), 0);
`endif
        chk("late_byte_en", {31'd0, en}, 32'd1);
        step();
        chk("late_byte_no_err", err_seen, exp_err);

`ifdef OPERAND_LOADER_CHECKSUM_EN
        send_frame(16'h00AB, 16'h00C3, 8'h05, 8'h00, 0, 1'b0);
        step();
        exp_err++;
        chk("ck_err_count", err_seen, exp_err);
        chk("ck_a_keep", {16'd0, a}, 32'hDEAD);
        chk("ck_c_keep", {24'd0, c}, 32'h77);
`endif

        // Reset after byte3 of a frame
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_a", {16'd0, a}, 32'd0);
        chk("mid_rst_b", {16'd0, b}, 32'd0);
        chk("mid_rst_c", {24'd0, c}, 32'd0);
        chk("mid_rst_en", {31'd0, en}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("mid_rst_ready", {31'd0, din_ready}, 32'd1);
        send_frame(16'h0102, 16'h0304, 8'h05, cks(16'h0102, 16'h0304, 8'h05), 0, 1'b1);
        step();
        chk("mid_rst_no_err", err_seen, exp_err);

        // Random gaps shorter than the timeout
        for (int n = 0; n < 6; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 8'($urandom);
            send_frame(ra, rb, rc, cks(ra, rb, rc), 2, 1'b1);
        end

        repeat (4) step();
        chk("queue_empty", q.size(), 0);
        chk("final_err_count", err_seen, exp_err);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
